prog_counter: RTL and testbench

Runtime-programmable, prescaled counter: WIDTH-bit value stepping by a programmable amount between runtime MIN/MAX bounds in one of five modes (wrap up/down, saturate up/down, ping-pong). Provides load, clear, terminal/wrap event pulses and a saturation flag. It is the general-purpose event/timebase counter for the design, configured from control registers instead of elaboration parameters.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/prog_counter_tick_gen.sv | 48 ++++
 rtl/prog_counter.sv | 162 ++++++++++++++++
 tb/tb_prog_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter family.
//
// counter_mode_t is the 3-bit mode encoding that every counter user drives
// onto its mode input. Encodings 5..7 are not named here; consumers treat them
// as MODE_UP.
package counter_pkg;

  typedef enum logic [2:0] {
    MODE_UP       = 3'd0,
    MODE_DOWN     = 3'd1,
    MODE_UPSAT    = 3'd2,
    MODE_DOWNSAT  = 3'd3,
    MODE_PINGPONG = 3'd4
  } counter_mode_t;

  // Map a raw mode field onto the enum, folding unused encodings onto UP.
  function automatic counter_mode_t decode_mode(input logic [2:0] raw);
    counter_mode_t m;
    if (raw > 3'd4) m = MODE_UP;
    else            m = counter_mode_t'(raw);
    return m;
  endfunction

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler for prog_counter: produces one tick every prescale_i+1 enabled
// cycles.
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_i       synchronous active-high reset (prescaler <= 0)
//   en_i        advance enable; low freezes the prescaler
//   clear_i     restart the prescaler from 0
//   hold_i      suppress ticks (bad bound configuration)
//   prescale_i  divide ratio minus one
//   tick_o      combinational tick, high in the cycle an update is taken
module tick_gen #(
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             hold_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_q, pre_d;

  // '>=' rather than '==' so that lowering prescale_i below the current
  // prescaler value produces a tick instead of a full rollover.
  assign tick_o = en_i & (pre_q >= prescale_i) & ~hold_i;

  always_comb begin
    pre_d = pre_q;
    if (clear_i) begin
      pre_d = '0;
    end else if (tick_o) begin
      pre_d = '0;
    end else if (en_i && (pre_q != '1)) begin
      // Saturate while ticks are held off so the prescaler never wraps back
      // to a small value and delays the first tick after the hold clears.
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/prog_counter.sv
// Runtime-programmable, prescaled event/timebase counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   en                  advance enable (freezes prescaler and count when low)
//   clear               count <= min_i, prescaler <= 0, dir <= up
//   load, load_val      count <= load_val (any value, even out of range)
//   mode_i              counter_mode_t (5..7 behave as UP)
//   min_i, max_i        inclusive unsigned bounds
//   step_i              increment per tick
//   prescale_i          tick every prescale_i+1 enabled cycles
//   count               registered count
//   tick                combinational, high when a count update is taken
//   wrap                registered pulse aligned with the post-wrap count
//   sat                 saturated at the active bound in UPSAT/DOWNSAT
//   dir                 direction of the next step (1 = up)
//   cfg_err             min_i > max_i; ticks are suppressed
module prog_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               PRE_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             sat,
  output logic             dir,
  output logic             cfg_err
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  counter_mode_t    mode;
  logic             go_up;
  logic             out_of_range;
  // One extra bit on every sum so bound comparisons never see an overflow.
  logic [WIDTH:0]   count_x, max_x, sum_x, floor_x;
  logic [WIDTH-1:0] diff;

  assign mode    = decode_mode(mode_i);
  assign cfg_err = (min_i > max_i);

  tick_gen #(.PRE_W(PRE_W)) u_tick_gen (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .clear_i    (clear),
    .hold_i     (cfg_err),
    .prescale_i (prescale_i),
    .tick_o     (tick)
  );

  // Only ping-pong keeps its own direction; other modes imply it.
  assign go_up = (mode == MODE_PINGPONG) ? dir_q
               : ((mode == MODE_UP) || (mode == MODE_UPSAT));

  assign count_x      = {1'b0, count_q};
  assign max_x        = {1'b0, max_i};
  assign sum_x        = count_x + {1'b0, step_i};
  assign floor_x      = {1'b0, min_i} + {1'b0, step_i};
  // Only used on paths where count_q >= min_i + step_i, so it cannot underflow.
  assign diff         = count_q - step_i;
  assign out_of_range = (count_q < min_i) || (count_q > max_i);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = min_i;
      dir_d   = 1'b1;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (step_i != '0)) begin
      if (out_of_range) begin
        // Re-enter the window at the bound the count is heading from.
        count_d = go_up ? min_i : max_i;
      end else begin
        case (mode)
          MODE_UP: begin
            if (sum_x > max_x) begin
              count_d = min_i;
              wrap_d  = 1'b1;
            end else begin
              count_d = sum_x[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            if (count_x < floor_x) begin
              count_d = max_i;
              wrap_d  = 1'b1;
            end else begin
              count_d = diff;
            end
          end
          MODE_UPSAT: begin
            count_d = (sum_x > max_x) ? max_i : sum_x[WIDTH-1:0];
          end
          MODE_DOWNSAT: begin
            count_d = (count_x < floor_x) ? min_i : diff;
          end
          MODE_PINGPONG: begin
            if (dir_q) begin
              if (sum_x >= max_x) begin
                count_d = max_i;
                dir_d   = 1'b0;
                wrap_d  = 1'b1;
              end else begin
                count_d = sum_x[WIDTH-1:0];
              end
            end else begin
              if (count_x <= floor_x) begin
                count_d = min_i;
                dir_d   = 1'b1;
                wrap_d  = 1'b1;
              end else begin
                count_d = diff;
              end
            end
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign dir   = go_up;
  assign sat   = ((mode == MODE_UPSAT)   && (count_q == max_i)) ||
                 ((mode == MODE_DOWNSAT) && (count_q == min_i));

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter (WIDTH=8, PRE_W=8, RST_VAL=0).
module tb_prog_counter;

  localparam int W  = 8;
  localparam int PW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, en, clear, load;
  logic [W-1:0]  load_val, min_i, max_i, step_i;
  logic [2:0]    mode_i;
  logic [PW-1:0] prescale_i;
  logic [W-1:0]  count;
  logic          tick, wrap, sat, dir, cfg_err;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(W), .PRE_W(PW), .RST_VAL(8'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .mode_i     (mode_i),
    .min_i      (min_i),
    .max_i      (max_i),
    .step_i     (step_i),
    .prescale_i (prescale_i),
    .count      (count),
    .tick       (tick),
    .wrap       (wrap),
    .sat        (sat),
    .dir        (dir),
    .cfg_err    (cfg_err)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst, clr, ld;
    logic [W-1:0]  lv;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  mn, mx, st;
    logic [PW-1:0] ps;
    logic          e_tick, e_cfg;
    logic [W-1:0]  e_cnt;
    logic          e_wrap, e_dir, e_sat;
  } vec_t;

  vec_t          vecs[$];
  logic [W+2:0]  exp_q[$];   // {count, wrap, dir, sat} after the edge
  int            n_vec = 0;
  int            n_err = 0;

  logic [2:0]    c_mode;
  logic [W-1:0]  c_mn, c_mx, c_st;
  logic [PW-1:0] c_ps;

  task automatic cfg(input logic [2:0] m, input logic [W-1:0] mn, mx, st,
                     input logic [PW-1:0] ps);
    c_mode = m; c_mn = mn; c_mx = mx; c_st = st; c_ps = ps;
  endtask

  task automatic add(input logic r, clr, ld, input logic [W-1:0] lv,
                     input logic e, et, ec, input logic [W-1:0] cnt,
                     input logic ew, ed, es);
    vec_t v;
    v.rst = r; v.clr = clr; v.ld = ld; v.lv = lv; v.en = e;
    v.mode = c_mode; v.mn = c_mn; v.mx = c_mx; v.st = c_st; v.ps = c_ps;
    v.e_tick = et; v.e_cfg = ec; v.e_cnt = cnt;
    v.e_wrap = ew; v.e_dir = ed; v.e_sat = es;
    vecs.push_back(v);
  endtask

  // Plain advance cycle with no control strobes.
  task automatic adv(input logic e, et, input logic [W-1:0] cnt,
                     input logic ew, ed, es);
    add(1'b0, 1'b0, 1'b0, 8'd0, e, et, 1'b0, cnt, ew, ed, es);
  endtask

  task automatic fill();
    // UP 4..30 then wrap to 4
    cfg(3'd0, 8'd4, 8'd30, 8'd1, 8'd0);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd4, 0, 1, 0);
    for (int c = 5; c <= 30; c++) adv(1, 1, 8'(c), 0, 1, 0);
    adv(1, 1, 8'd4, 1, 1, 0);
    // step 0: tick pulses, count holds, no wrap
    cfg(3'd0, 8'd4, 8'd30, 8'd0, 8'd0);
    adv(1, 1, 8'd4, 0, 1, 0);
    // unused encoding 7 behaves as UP
    cfg(3'd7, 8'd4, 8'd30, 8'd1, 8'd0);
    adv(1, 1, 8'd5, 0, 1, 0);
    // UPSAT 10,14,15,15
    cfg(3'd2, 8'd10, 8'd15, 8'd4, 8'd0);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd10, 0, 1, 0);
    adv(1, 1, 8'd14, 0, 1, 0);
    adv(1, 1, 8'd15, 0, 1, 1);
    adv(1, 1, 8'd15, 0, 1, 1);
    // DOWNSAT 9,5,3,3
    cfg(3'd3, 8'd3, 8'd9, 8'd4, 8'd0);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd3, 0, 0, 1);
    add(0, 0, 1, 8'd9, 0, 0, 0, 8'd9, 0, 0, 0);
    adv(1, 1, 8'd5, 0, 0, 0);
    adv(1, 1, 8'd3, 0, 0, 1);
    adv(1, 1, 8'd3, 0, 0, 1);
    // DOWN wrap: 9 -> 15 (wrap) -> 11
    cfg(3'd1, 8'd6, 8'd15, 8'd4, 8'd0);
    add(0, 0, 1, 8'd9, 0, 0, 0, 8'd9, 0, 0, 0);
    adv(1, 1, 8'd15, 1, 0, 0);
    adv(1, 1, 8'd11, 0, 0, 0);
    // PINGPONG 2,5,8,5,2,5
    cfg(3'd4, 8'd2, 8'd8, 8'd3, 8'd0);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd2, 0, 1, 0);
    adv(1, 1, 8'd5, 0, 1, 0);
    adv(1, 1, 8'd8, 1, 0, 0);
    adv(1, 1, 8'd5, 0, 0, 0);
    adv(1, 1, 8'd2, 1, 1, 0);
    adv(1, 1, 8'd5, 0, 1, 0);
    // clear beats load; out-of-range load re-enters at min without wrap
    cfg(3'd0, 8'd4, 8'd30, 8'd1, 8'd0);
    add(0, 1, 1, 8'd99, 0, 0, 0, 8'd4, 0, 1, 0);
    add(0, 0, 1, 8'd200, 0, 0, 0, 8'd200, 0, 1, 0);
    adv(1, 1, 8'd4, 0, 1, 0);
    // min > max: no tick, count holds
    cfg(3'd0, 8'd20, 8'd10, 8'd1, 8'd0);
    add(0, 0, 0, 8'd0, 1, 0, 1, 8'd4, 0, 1, 0);
    add(0, 0, 0, 8'd0, 1, 0, 1, 8'd4, 0, 1, 0);
    // DOWN, prescale 7: 8 enabled cycles per tick; 3 idle cycles stretch it
    cfg(3'd1, 8'd6, 8'd15, 8'd1, 8'd7);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd6, 0, 0, 0);
    add(0, 0, 1, 8'd15, 0, 0, 0, 8'd15, 0, 0, 0);
    for (int i = 0; i < 7; i++) adv(1, 0, 8'd15, 0, 0, 0);
    adv(1, 1, 8'd14, 0, 0, 0);
    for (int i = 0; i < 2; i++) adv(1, 0, 8'd14, 0, 0, 0);
    for (int i = 0; i < 3; i++) adv(0, 0, 8'd14, 0, 0, 0);
    for (int i = 0; i < 5; i++) adv(1, 0, 8'd14, 0, 0, 0);
    adv(1, 1, 8'd13, 0, 0, 0);
    // rst during a tick (with load): prescaler restarts from 0
    cfg(3'd0, 8'd0, 8'd100, 8'd5, 8'd3);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) adv(1, 0, 8'd0, 0, 1, 0);
    adv(1, 1, 8'd5, 0, 1, 0);
    for (int i = 0; i < 3; i++) adv(1, 0, 8'd5, 0, 1, 0);
    add(1, 0, 1, 8'd77, 1, 1, 0, 8'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) adv(1, 0, 8'd0, 0, 1, 0);
    adv(1, 1, 8'd5, 0, 1, 0);
    // rst while ping-pong heads down: dir returns to up
    cfg(3'd4, 8'd2, 8'd8, 8'd3, 8'd0);
    add(0, 1, 0, 8'd0, 0, 0, 0, 8'd2, 0, 1, 0);
    adv(1, 1, 8'd5, 0, 1, 0);
    adv(1, 1, 8'd8, 1, 0, 0);
    add(1, 0, 0, 8'd0, 1, 1, 0, 8'd0, 0, 1, 0);
    adv(1, 1, 8'd2, 0, 1, 0);
    adv(1, 1, 8'd5, 0, 1, 0);
  endtask

  // ---------------- checks ----------------
  task automatic chk1(input string name, input int idx, input logic got, exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %b expected %b", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [W+2:0] got_s, exp_s;
    rst = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    mode_i = 3'd0; min_i = '0; max_i = '0; step_i = '0; prescale_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({count, dir, wrap} !== {8'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got count=%0d dir=%b wrap=%b expected count=0 dir=1 wrap=0",
               count, dir, wrap);
    end

    fill();
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; clear = vecs[i].clr; load = vecs[i].ld;
      load_val = vecs[i].lv; en = vecs[i].en; mode_i = vecs[i].mode;
      min_i = vecs[i].mn; max_i = vecs[i].mx; step_i = vecs[i].st;
      prescale_i = vecs[i].ps;
      #1;
      n_vec++;
      chk1("tick", i, tick, vecs[i].e_tick);
      chk1("cfg_err", i, cfg_err, vecs[i].e_cfg);
      exp_q.push_back({vecs[i].e_cnt, vecs[i].e_wrap, vecs[i].e_dir, vecs[i].e_sat});
      @(posedge clk);
      #1;
      got_s = {count, wrap, dir, sat};
      exp_s = exp_q.pop_front();
      if (got_s !== exp_s) begin
        n_err++;
        $display("FAIL state vec %0d: got count=%0d wrap=%b dir=%b sat=%b expected count=%0d wrap=%b dir=%b sat=%b",
                 i, got_s[W+2:3], got_s[2], got_s[1], got_s[0],
                 exp_s[W+2:3], exp_s[2], exp_s[1], exp_s[0]);
      end
    end
    rst = 1'b0;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
